// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a registered line output.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_data_valid,
  output logic                         tx_data_ready,
  output logic                         tx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_q, bit_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic                tx_q, tx_d;
  logic                busy_q;
  logic                ready_q;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [7:0]          mem [FIFO_DEPTH];

  logic                wr_en;
  logic                pop;
  logic                fifo_nonempty;
  logic                bit_end;
  logic [7:0]          head;

  assign wr_en         = tx_data_valid && ready_q;
  assign fifo_nonempty = (count_q != '0);
  assign bit_end       = (cyc_q == CNT_W'(CLKS_PER_BIT - 1));
  assign head          = mem[rd_ptr_q];
  assign count_d       = count_q + FCNT_W'(wr_en) - FCNT_W'(pop);

  assign tx_data_ready = ready_q;
  assign tx            = tx_q;
  assign tx_busy       = busy_q;
  assign fifo_count    = count_q;

  // Next-state and serializer datapath; pops happen only from IDLE or at the end of STOP.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cyc_d = '0;
        bit_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // FSM state, serializer registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // FIFO occupancy and pointers; ready tracks the registered count so a same-cycle pop never frees a slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      ready_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != FCNT_W'(FIFO_DEPTH));
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= tx_data;
  end

endmodule
